// File: rtl/komut_getir.sv
// komut_getir: instruction fetch unit with a valid/ready memory port, credit-based
// prefetch FIFO, redirect/flush handling and fault tagging of delivered entries.

// Overflow/underflow watchdog for the fetch unit's counters and FIFO.
module komut_getir_denetci #(
   parameter int DERINLIK = 4,
   parameter int CW       = 3
) (
   input logic          clk,
   input logic          reset,
   input logic [CW-1:0] doluluk,
   input logic [CW-1:0] ucus,
   input logic [CW-1:0] atla,
   input logic          push,
   input logic          pop,
   input logic          flush
);
   localparam logic [CW-1:0] KAP = CW'(DERINLIK);

   a_doluluk: assert property (@(posedge clk) disable iff (reset) doluluk <= KAP);
   a_ucus:    assert property (@(posedge clk) disable iff (reset) ucus <= KAP);
   a_atla:    assert property (@(posedge clk) disable iff (reset) atla <= ucus);
   a_tasma:   assert property (@(posedge clk) disable iff (reset)
                               !(push && !pop && !flush && (doluluk == KAP)));
   a_bosalma: assert property (@(posedge clk) disable iff (reset)
                               !(pop && (doluluk == {CW{1'b0}})));
endmodule

module komut_getir #(
   parameter int              XLEN     = 32,
   parameter int              ILEN     = 32,
   parameter int              DERINLIK = 4,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
   input  logic            clk,
   input  logic            reset,
   output logic            bellek_istek_gecerli,
   input  logic            bellek_istek_hazir,
   output logic [XLEN-1:0] bellek_adres,
   input  logic            bellek_yanit_gecerli,
   input  logic [ILEN-1:0] bellek_yanit_veri,
   input  logic            bellek_yanit_hata,
   input  logic            yonlendir,
   input  logic [XLEN-1:0] yonlendir_pc,
   output logic            komut_gecerli,
   input  logic            komut_hazir,
   output logic [ILEN-1:0] komut,
   output logic [XLEN-1:0] pc,
   output logic            hata
);
   localparam int              AW         = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
   localparam int              CW         = $clog2(DERINLIK) + 1;
   localparam logic [XLEN-1:0] ADIM       = XLEN'(ILEN / 8);
   localparam logic [XLEN-1:0] HIZA_MASKE = XLEN'(ILEN / 8 - 1);
   localparam logic [CW:0]     KAPASITE   = (CW + 1)'(DERINLIK);

   typedef enum logic [0:0] {GETIR = 1'b0, DUR = 1'b1} durum_t;

   durum_t          durum_r, durum_n_s;
   logic [XLEN-1:0] getir_pc_r, getir_pc_n_s;
   logic [XLEN-1:0] yanit_pc_r, yanit_pc_n_s;
   logic [CW-1:0]   ucus_r, ucus_n_s;
   logic [CW-1:0]   atla_r, atla_n_s;
   logic [CW-1:0]   doluluk_r;
   logic [AW-1:0]   yaz_r, oku_r, yaz_adr_s;

   logic [ILEN-1:0]     komut_mem_r [DERINLIK];
   logic [XLEN-1:0]     pc_mem_r    [DERINLIK];
   logic [DERINLIK-1:0] hata_mem_r;

   logic            istek_hs_s, yanit_al_s, pop_s, bos_s, hizali_s;
   logic            push_s, flush_s, push_hata_s;
   logic [ILEN-1:0] push_komut_s;
   logic [XLEN-1:0] push_pc_s;

   // Request side: a credit is free only while in-flight plus buffered stays below depth.
   assign bellek_istek_gecerli = !reset && (durum_r == GETIR) && !yonlendir &&
                                 (({1'b0, ucus_r} + {1'b0, doluluk_r}) < KAPASITE);
   assign bellek_adres = getir_pc_r;
   assign istek_hs_s   = bellek_istek_gecerli && bellek_istek_hazir;
   // A response with nothing outstanding is a leftover from before reset and is ignored.
   assign yanit_al_s   = bellek_yanit_gecerli && (ucus_r != {CW{1'b0}});
   assign hizali_s     = ((yonlendir_pc & HIZA_MASKE) == {XLEN{1'b0}});

   // Decode side: head entry straight from FIFO storage, zero while empty.
   assign bos_s         = (doluluk_r == {CW{1'b0}});
   assign komut_gecerli = !bos_s;
   assign komut         = bos_s ? {ILEN{1'b0}} : komut_mem_r[oku_r];
   assign pc            = bos_s ? {XLEN{1'b0}} : pc_mem_r[oku_r];
   assign hata          = bos_s ? 1'b0 : hata_mem_r[oku_r];
   assign pop_s         = komut_gecerli && komut_hazir;
   assign yaz_adr_s     = flush_s ? {AW{1'b0}} : yaz_r;

   // Next-state: redirect first, then normal request/response bookkeeping and fault stop.
   always_comb begin
      durum_n_s    = durum_r;
      getir_pc_n_s = getir_pc_r;
      yanit_pc_n_s = yanit_pc_r;
      ucus_n_s     = ucus_r + {{(CW-1){1'b0}}, istek_hs_s} - {{(CW-1){1'b0}}, yanit_al_s};
      atla_n_s     = atla_r;
      push_s       = 1'b0;
      flush_s      = 1'b0;
      push_komut_s = {ILEN{1'b0}};
      push_pc_s    = {XLEN{1'b0}};
      push_hata_s  = 1'b0;
      if (yonlendir) begin
         flush_s      = 1'b1;
         atla_n_s     = ucus_n_s;
         getir_pc_n_s = yonlendir_pc;
         yanit_pc_n_s = yonlendir_pc;
         if (hizali_s) begin
            durum_n_s = GETIR;
         end else begin
            push_s      = 1'b1;
            push_pc_s   = yonlendir_pc;
            push_hata_s = 1'b1;
            durum_n_s   = DUR;
         end
      end else begin
         if (istek_hs_s) begin
            getir_pc_n_s = getir_pc_r + ADIM;
         end else begin
            getir_pc_n_s = getir_pc_r;
         end
         if (yanit_al_s && (atla_r != {CW{1'b0}})) begin
            atla_n_s = atla_r - {{(CW-1){1'b0}}, 1'b1};
         end else if (yanit_al_s && (durum_r == GETIR)) begin
            push_s       = 1'b1;
            push_komut_s = bellek_yanit_veri;
            push_pc_s    = yanit_pc_r;
            push_hata_s  = bellek_yanit_hata;
            yanit_pc_n_s = yanit_pc_r + ADIM;
            if (bellek_yanit_hata) begin
               durum_n_s = DUR;
               atla_n_s  = ucus_n_s;
            end else begin
               durum_n_s = durum_r;
            end
         end else begin
            atla_n_s = atla_r;
         end
      end
   end

   // Control registers: state, fetch/response pcs and the two counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         durum_r    <= GETIR;
         getir_pc_r <= RESET_PC;
         yanit_pc_r <= RESET_PC;
         ucus_r     <= {CW{1'b0}};
         atla_r     <= {CW{1'b0}};
      end else begin
         durum_r    <= durum_n_s;
         getir_pc_r <= getir_pc_n_s;
         yanit_pc_r <= yanit_pc_n_s;
         ucus_r     <= ucus_n_s;
         atla_r     <= atla_n_s;
      end
   end

   // FIFO pointers and occupancy; a flush restarts at slot 0 with the optional fault entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         yaz_r     <= {AW{1'b0}};
         oku_r     <= {AW{1'b0}};
         doluluk_r <= {CW{1'b0}};
      end else if (flush_s) begin
         oku_r     <= {AW{1'b0}};
         yaz_r     <= push_s ? AW'(1) : {AW{1'b0}};
         doluluk_r <= push_s ? CW'(1) : {CW{1'b0}};
      end else begin
         if (push_s) begin
            yaz_r <= yaz_r + AW'(1);
         end
         if (pop_s) begin
            oku_r <= oku_r + AW'(1);
         end
         doluluk_r <= doluluk_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
      end
   end

   // FIFO storage write; contents are don't-care until occupancy marks them valid.
   always_ff @(posedge clk) begin
      if (push_s) begin
         komut_mem_r[yaz_adr_s] <= push_komut_s;
         pc_mem_r[yaz_adr_s]    <= push_pc_s;
         hata_mem_r[yaz_adr_s]  <= push_hata_s;
      end
   end

   komut_getir_denetci #(.DERINLIK(DERINLIK), .CW(CW)) u_denetci (
      .clk     (clk),
      .reset   (reset),
      .doluluk (doluluk_r),
      .ucus    (ucus_r),
      .atla    (atla_r),
      .push    (push_s),
      .pop     (pop_s),
      .flush   (flush_s)
   );
endmodule
